// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the USB-serial to-host byte arbiter.
// Holds the arbiter state encoding, the tag byte base, default parameter
// values and the round-robin pointer increment helper.
package uart_arb_pkg;

  // Arbiter FSM states. TAG is only reachable when UART_ARB_TAG_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // Tag byte emitted ahead of each message; low bits carry the requester id.
  localparam logic [7:0] TAG_BASE = 8'hF0;

  // Default number of requesters sharing the stream.
  localparam int DEFAULT_NUM_REQ = 4;

  // Default stall timeout: 100 us at 48 MHz.
  localparam int DEFAULT_TIMEOUT = 4800;

  // Next round-robin start position after requester 'cur', wrapping modulo n
  // (also correct for non-power-of-two n).
  function automatic int rr_next(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
// Searches the request vector upward from ptr_i with wrap-around and returns
// the first set bit. Kept generic so other arbiters can reuse it.
module uart_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 found_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int W = $clog2(N);

  // One extra bit so ptr + offset can exceed N-1 before the wrap correction.
  logic [W:0] cand;

  // Scan N candidates starting at ptr_i; the first requesting one wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_i} + (W+1)'(i);
      if (cand >= (W+1)'(N)) begin
        cand = cand - (W+1)'(N);
      end
      if (!found_o && req_i[cand[W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the usb_uart to-host byte stream among several
// on-chip message sources. Grants last a whole message (until the granted
// requester's last byte is accepted) or until the requester stalls for
// TIMEOUT cycles with nothing to send.
//
// Optional feature macro: UART_ARB_TAG_EN -- when defined, every message is
// preceded by one tag byte (TAG_BASE | grant_id); when undefined the output
// is the raw concatenation of messages.
//
// Handshake: on every port a byte moves on a rising clock edge exactly when
// valid and ready are both high in that cycle. A source holding valid high
// must keep data/last stable until it is accepted; ready may be high without
// valid and carries no obligation by itself.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                       clk_48mhz,
  input  logic                       reset,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 uart_in_data,
  output logic                       uart_in_valid,
  input  logic                       uart_in_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [1:0]                 dbg_state_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  // FSM state
  arb_state_e state_q, state_d;

  // Grant, round-robin pointer and stall counter
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Output holding register and timeout pulse
  logic             hold_valid_q, hold_valid_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             tmo_q, tmo_d;

  // Picker results
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  // Decoded per-cycle actions (FSM outputs)
  logic               slot_free;
  logic               start;
  logic               load_tag;
  logic               accept;
  logic               cnt_inc;
  logic               expire;
  logic               release_grant;
  logic [NUM_REQ-1:0] ready_c;

  // Granted requester's lane
  logic               gnt_valid;
  logic               gnt_last;
  logic [7:0]         gnt_data;
  logic [IDX_W-1:0]   next_ptr;

  assign gnt_valid = req_valid[grant_q];
  assign gnt_last  = req_last[grant_q];
  assign gnt_data  = req_data[{grant_q, 3'b000} +: 8];

  // The holding register can take a byte when empty or when it drains this cycle.
  assign slot_free = ~hold_valid_q | uart_in_ready;

  assign release_grant = (accept & gnt_last) | expire;
  assign next_ptr      = IDX_W'(rr_next(int'(grant_q), NUM_REQ));

  uart_rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // FSM state register
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
`ifdef UART_ARB_TAG_EN
          state_d = ST_TAG;
`else
          state_d = ST_DATA;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        if (slot_free) begin
          state_d = ST_DATA;
        end
      end
`endif
      ST_DATA: begin
        if (release_grant) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: per-cycle actions and the requester ready vector
  always_comb begin
    start    = 1'b0;
    load_tag = 1'b0;
    accept   = 1'b0;
    cnt_inc  = 1'b0;
    expire   = 1'b0;
    ready_c  = '0;
    case (state_q)
      ST_IDLE: begin
        start = pick_found;
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        load_tag = slot_free;
      end
`endif
      ST_DATA: begin
        ready_c[grant_q] = slot_free;
        accept           = gnt_valid & slot_free;
        // Only a silent requester counts toward the timeout; backpressure does not.
        if (!gnt_valid) begin
          if (cnt_q == CNT_MAX) begin
            expire = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        start = 1'b0;
      end
    endcase
  end

  // Datapath next-state: grant capture, pointer advance, counter, holding register
  always_comb begin
    grant_d      = grant_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    tmo_d        = expire;

    if (start) begin
      grant_d = pick_idx;
      cnt_d   = '0;
    end else if (accept) begin
      cnt_d = '0;
    end else if (cnt_inc) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (release_grant) begin
      rr_d = next_ptr;
    end

    if (load_tag) begin
      hold_valid_d = 1'b1;
      hold_data_d  = TAG_BASE | {{(8-IDX_W){1'b0}}, grant_q};
    end else if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = gnt_data;
    end else if (uart_in_ready) begin
      hold_valid_d = 1'b0;
    end
  end

  // Datapath registers; reset drops any byte still in the holding register
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      grant_q      <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'h00;
      tmo_q        <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      tmo_q        <= tmo_d;
    end
  end

  // timeout_err is registered: it pulses in the first IDLE cycle after a forced release.
  assign req_ready     = ready_c;
  assign uart_in_data  = hold_data_q;
  assign uart_in_valid = hold_valid_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign timeout_err   = tmo_q;
  assign dbg_state_o   = state_q;

endmodule
